jt6295_seq_n: RTL and testbench
===============================

// Module: jt6295_seq_n
// PURPOSE
//  Parametrised N-channel ADPCM sequencer. Time-multiplexes CH voices over one ROM port.
//  Per slot it fetches the voice's current byte, emits one nibble with attenuation to the
//  decoder pipe, and advances the nibble counter. Versus the 4-ch serializer it adds:
//  - CH/AW generics; - per-voice loop mode; - rom_ok stall handshake; - start/stop ack pulses.
// PARAMETERS
//  CH   4   number of voices (>=2); CHW = $clog2(CH)
//  AW   18  ROM byte address width
//  ATW  4   attenuation code width
// PORTS
//  clk        in   1     system clock
//  rst_n      in   1     asynchronous, active-low reset
//  cen        in   1     slot clock enable (one slot per advancing cen)
//  start_addr in   AW    start byte address, used on start
//  stop_addr  in   AW    last byte address (inclusive), used on start
//  att        in   ATW   attenuation, used on start
//  loop       in   1     loop mode, used on start
//  start      in   CH    per-voice start request, level, held until ack
//  stop       in   CH    per-voice stop request, level, held until ack
//  ack        out  CH    one-clk pulse: request of that voice consumed
//  busy       out  CH    voice playing
//  zero       out  1     current slot == 0
//  rom_addr   out  AW    byte address of current slot (combinational from slot state)
//  rom_cs     out  1     current slot voice busy, fetch required
//  rom_data   in   8     ROM byte for rom_addr
//  rom_ok     in   1     rom_data valid for rom_addr this cycle
//  pipe_stb   out  1     one-clk pulse per slot advance
//  pipe_ch    out  CHW   voice index of pipe data
//  pipe_en    out  1     pipe nibble valid (voice was playing)
//  pipe_att   out  ATW   voice attenuation
//  pipe_data  out  4     ADPCM nibble
// BEHAVIOUR
//  - Reset: slot=0, all voice regs (cnt, stop, lp, att, loop, busy) = 0; ack=0, busy=0,
//    pipe_*=0, zero=1. Reset mid-play aborts all voices at once; no ack issued.
//  - Per-voice regs: cnt[AW:0] nibble counter (bit0=0 high nibble, 1 low), stop[AW-1:0],
//    lp[AW-1:0] loop start, att, loop, busy. Held in arrays indexed by slot.
//  - adv = cen & (rom_ok | ~rom_cs). Stall (cen & rom_cs & ~rom_ok): slot, voice regs,
//    pipe_* hold; no ack; request stays pending. Slot = (slot==CH-1) ? 0 : slot+1 on adv.
//  - rom_addr = cnt[slot][AW:1]; rom_cs = busy[slot]; zero = (slot==0).
//  - On adv, voice v=slot, evaluated in priority order (old values used for pipe):
//    1 stop[v]: busy<=0; ack[v] pulse. If start[v] also high: regs loaded, busy stays 0.
//    2 start[v]: cnt<={start_addr,0}, stop<=stop_addr, lp<=start_addr, att, loop latched,
//      busy<=1; ack[v] pulse. Restart of a busy voice allowed (retriggers).
//    3 busy & cnt=={stop,1}: loop ? cnt<={lp,0} : busy<=0.
//    4 busy otherwise: cnt<=cnt+1 (width AW+1, wraps at top of ROM).
//    5 idle: no change.
//  - Both nibbles of stop byte play; stop_addr<start_addr plays through ROM wrap to stop.
//  - Pipe (registered on adv, 1 clk latency from adv): pipe_stb=1, pipe_ch=slot,
//    pipe_en=old busy, pipe_att=old att,
//    pipe_data = old cnt[0] ? rom_data[3:0] : rom_data[7:4]. pipe_stb=0 on all other cycles.
//  - A start-slot pipe entry carries the previous state (pipe_en=0 if voice was idle);
//    first new nibble is emitted on the voice's next slot.
//  - busy[v] reflects the registered voice busy; ack is registered, same edge as state update.
// TESTING
//  1 CH=4, rom_ok=1, cen every clk; start[1], start=0x100, stop=0x101 -> ack[1] at slot1;
//    then 4 pipe_en nibbles for ch1 (hi/lo of 0x100, hi/lo of 0x101), then busy[1]=0.
//  2 Same with loop=1 -> nibble order 0x100H,0x100L,0x101H,0x101L,0x100H..., busy stays 1;
//    then stop[1] -> ack, busy[1]=0, next ch1 entry pipe_en=0.
//  3 rom_ok held 0 for 5 clks while slot2 busy -> slot/rom_addr frozen, no pipe_stb;
//    resumes with same nibble, no skipped or duplicated data.
//  4 start[0]&stop[0] together -> single ack[0], busy[0]=0, no playback.
//  5 Two voices at 0x3FFFF..0x00000 (AW=18) -> addresses wrap to 0x00000, correct end.
//  6 rst_n low mid-play, CH=8 -> all outputs 0 asynchronously, zero=1; restart works.

Source files
------------

// File: rtl/jt6295_seq_n.sv
// jt6295_seq_n: N-voice ADPCM sequencer.
// A slot counter walks the voices round-robin and shares one ROM port among them.
// On each slot the current voice's byte is fetched, one nibble is forwarded to the
// decoder pipe, and that voice's nibble counter is advanced.
// A slot whose voice is playing waits for rom_ok before it advances.
module jt6295_seq_n #(
  parameter  int CH  = 4,
  parameter  int AW  = 18,
  parameter  int ATW = 4,
  localparam int CHW = $clog2(CH)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cen,
  input  logic [AW-1:0]  start_addr,
  input  logic [AW-1:0]  stop_addr,
  input  logic [ATW-1:0] att,
  input  logic           loop,
  input  logic [CH-1:0]  start,
  input  logic [CH-1:0]  stop,
  output logic [CH-1:0]  ack,
  output logic [CH-1:0]  busy,
  output logic           zero,
  output logic [AW-1:0]  rom_addr,
  output logic           rom_cs,
  input  logic [7:0]     rom_data,
  input  logic           rom_ok,
  output logic           pipe_stb,
  output logic [CHW-1:0] pipe_ch,
  output logic           pipe_en,
  output logic [ATW-1:0] pipe_att,
  output logic [3:0]     pipe_data
);

  logic [CHW-1:0] slot_reg;
  logic [CHW-1:0] slot_next;
  logic           adv;

  // Per-voice state gathered into slot-indexed views for the shared datapath
  logic [AW:0]    cnt_arr [CH];
  logic [ATW-1:0] att_arr [CH];
  logic [CH-1:0]  busy_vec;
  logic [CH-1:0]  ack_vec;
  logic [AW:0]    cur_cnt;

  assign cur_cnt  = cnt_arr[slot_reg];
  assign rom_addr = cur_cnt[AW:1];
  assign rom_cs   = busy_vec[slot_reg];
  assign zero     = (slot_reg == '0);
  // An idle slot never needs ROM data, so it advances without waiting for rom_ok
  assign adv      = cen & (rom_ok | ~rom_cs);
  assign busy     = busy_vec;
  assign ack      = ack_vec;

  // Next slot: wrap after the last voice (CH need not be a power of two)
  always_comb begin
    slot_next = slot_reg;
    if (slot_reg == CHW'(CH - 1)) slot_next = '0;
    else                          slot_next = slot_reg + 1'b1;
  end

  // Slot counter moves only on an advancing enable; a stall freezes it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   slot_reg <= '0;
    else if (adv) slot_reg <= slot_next;
  end

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_voice
      logic [AW:0]    cnt_reg;
      logic [AW-1:0]  stop_reg;
      logic [AW-1:0]  lp_reg;
      logic [ATW-1:0] att_reg;
      logic           loop_reg;
      logic           busy_reg;
      logic           ack_reg;
      logic           sel;
      logic           at_end;

      assign sel    = adv && (slot_reg == CHW'(gi));
      // Last nibble is the low nibble of the stop byte
      assign at_end = (cnt_reg == {stop_reg, 1'b1});

      assign cnt_arr[gi]  = cnt_reg;
      assign att_arr[gi]  = att_reg;
      assign busy_vec[gi] = busy_reg;
      assign ack_vec[gi]  = ack_reg;

      // Voice update on its own slot: stop beats start, start beats playback
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg  <= '0;
          stop_reg <= '0;
          lp_reg   <= '0;
          att_reg  <= '0;
          loop_reg <= 1'b0;
          busy_reg <= 1'b0;
          ack_reg  <= 1'b0;
        end else begin
          ack_reg <= sel & (start[gi] | stop[gi]);
          if (sel) begin
            if (start[gi]) begin
              // Parameters load even when a simultaneous stop keeps the voice idle
              cnt_reg  <= {start_addr, 1'b0};
              stop_reg <= stop_addr;
              lp_reg   <= start_addr;
              att_reg  <= att;
              loop_reg <= loop;
            end
            if (stop[gi]) begin
              busy_reg <= 1'b0;
            end else if (start[gi]) begin
              busy_reg <= 1'b1;
            end else if (busy_reg && at_end) begin
              if (loop_reg) cnt_reg  <= {lp_reg, 1'b0};
              else          busy_reg <= 1'b0;
            end else if (busy_reg) begin
              // Counter is AW+1 wide so playback wraps past the top of ROM
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
      end
    end
  endgenerate

  // Pipe entry for the slot just served, built from its pre-update state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_stb  <= 1'b0;
      pipe_ch   <= '0;
      pipe_en   <= 1'b0;
      pipe_att  <= '0;
      pipe_data <= '0;
    end else if (adv) begin
      pipe_stb  <= 1'b1;
      pipe_ch   <= slot_reg;
      pipe_en   <= busy_vec[slot_reg];
      pipe_att  <= att_arr[slot_reg];
      pipe_data <= cur_cnt[0] ? rom_data[3:0] : rom_data[7:4];
    end else begin
      pipe_stb  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_jt6295_seq_n.sv
// Directed bench for jt6295_seq_n: a 4-voice instance for the playback scenarios
// and an 8-voice instance for the asynchronous reset scenario.
module tb_jt6295_seq_n;
  localparam int AW  = 18;
  localparam int ATW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n, rst8_n, cen, loop, rom_ok;
  logic [AW-1:0]  start_addr, stop_addr;
  logic [ATW-1:0] att;

  logic [3:0]     start, stop, ack, busy;
  logic           zero, rom_cs, pipe_stb, pipe_en;
  logic [AW-1:0]  rom_addr;
  logic [7:0]     rom_data;
  logic [1:0]     pipe_ch;
  logic [3:0]     pipe_att, pipe_data;

  logic [7:0]     start8, stop8, ack8, busy8;
  logic           zero8, rom_cs8, pipe_stb8, pipe_en8;
  logic [AW-1:0]  rom_addr8;
  logic [7:0]     rom_data8;
  logic [2:0]     pipe_ch8;
  logic [3:0]     pipe_att8, pipe_data8;

  int total = 0;
  int bad   = 0;

  // ROM contents: byte = (a[7:0] + 0x5A) ^ {a[17:14], a[11:8]}
  function automatic logic [7:0] romf(input logic [AW-1:0] a);
    return (a[7:0] + 8'h5A) ^ {a[17:14], a[11:8]};
  endfunction

  assign rom_data  = romf(rom_addr);
  assign rom_data8 = romf(rom_addr8);

  jt6295_seq_n #(.CH(4), .AW(AW), .ATW(ATW)) dut (
    .clk(clk), .rst_n(rst_n), .cen(cen), .start_addr(start_addr), .stop_addr(stop_addr),
    .att(att), .loop(loop), .start(start), .stop(stop), .ack(ack), .busy(busy),
    .zero(zero), .rom_addr(rom_addr), .rom_cs(rom_cs), .rom_data(rom_data), .rom_ok(rom_ok),
    .pipe_stb(pipe_stb), .pipe_ch(pipe_ch), .pipe_en(pipe_en), .pipe_att(pipe_att),
    .pipe_data(pipe_data)
  );

  jt6295_seq_n #(.CH(8), .AW(AW), .ATW(ATW)) dut8 (
    .clk(clk), .rst_n(rst8_n), .cen(cen), .start_addr(start_addr), .stop_addr(stop_addr),
    .att(att), .loop(loop), .start(start8), .stop(stop8), .ack(ack8), .busy(busy8),
    .zero(zero8), .rom_addr(rom_addr8), .rom_cs(rom_cs8), .rom_data(rom_data8), .rom_ok(rom_ok),
    .pipe_stb(pipe_stb8), .pipe_ch(pipe_ch8), .pipe_en(pipe_en8), .pipe_att(pipe_att8),
    .pipe_data(pipe_data8)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(input int ch);
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      tick();
      n++;
      if (ack[ch] === 1'b1) got = 1'b1;
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL ack_wait ch=%0d got=no_ack want=ack", ch);
    end else
      $display("ack ch=%0d", ch);
  endtask

  task automatic next_entry(input int ch, output logic en, output logic [3:0] d,
                            output logic [3:0] a);
    int n;
    bit got;
    n = 0;
    got = 1'b0;
    en = 1'bx;
    d = 'x;
    a = 'x;
    while (!got && n < 64) begin
      tick();
      n++;
      if (pipe_stb === 1'b1 && pipe_ch === 2'(ch)) begin
        got = 1'b1;
        en = pipe_en;
        d = pipe_data;
        a = pipe_att;
      end
    end
    total++;
    if (!got) begin
      bad++;
      $display("FAIL entry_wait ch=%0d got=none want=entry", ch);
    end else
      $display("entry ch=%0d en=%0b att=%h data=%h", ch, en, a, d);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; rst8_n = 1'b0; cen = 1'b1; rom_ok = 1'b1; loop = 1'b0;
    start = '0; stop = '0; start8 = '0; stop8 = '0;
    start_addr = '0; stop_addr = '0; att = '0;
    tick();
    tick();
    total++; if (zero !== 1'b1)   begin bad++; $display("FAIL rst_zero got=%b want=1", zero); end
    total++; if (busy !== 4'h0)   begin bad++; $display("FAIL rst_busy got=%h want=0", busy); end
    total++; if (ack !== 4'h0)    begin bad++; $display("FAIL rst_ack got=%h want=0", ack); end
    total++; if ({pipe_stb, pipe_en, pipe_ch, pipe_att, pipe_data} !== 12'h0) begin
      bad++; $display("FAIL rst_pipe got=%h want=0", {pipe_stb, pipe_en, pipe_ch, pipe_att, pipe_data});
    end
    total++; if ({rom_cs, rom_addr} !== 19'h0) begin
      bad++; $display("FAIL rst_rom got=%h want=0", {rom_cs, rom_addr});
    end
    rst_n = 1'b1;
    tick();
    total++; if (zero !== 1'b0) begin bad++; $display("FAIL slot1_zero got=%b want=0", zero); end
    tick(); tick(); tick();
    total++; if (zero !== 1'b1) begin bad++; $display("FAIL slot_wrap_zero got=%b want=1", zero); end
  endtask

  // One-shot play of 0x100..0x101 on voice 1: bytes 0x5B, 0x5A
  task automatic test_play_once();
    logic       en;
    logic [3:0] d, a;
    logic [3:0] exp_d [4];
    exp_d = '{4'h5, 4'hB, 4'h5, 4'hA};
    start_addr = 18'h00100; stop_addr = 18'h00101; att = 4'h9; loop = 1'b0;
    start = 4'b0010;
    wait_ack(1);
    total++; if (busy[1] !== 1'b1) begin bad++; $display("FAIL once_busy got=%b want=1", busy[1]); end
    total++; if (pipe_ch !== 2'd1 || pipe_en !== 1'b0) begin
      bad++; $display("FAIL once_start_entry got=ch%0d en%b want=ch1 en0", pipe_ch, pipe_en);
    end
    start = '0;
    for (int i = 0; i < 4; i++) begin
      next_entry(1, en, d, a);
      total++;
      if (en !== 1'b1 || d !== exp_d[i] || a !== 4'h9) begin
        bad++; $display("FAIL once_nib%0d got=en%b d%h a%h want=en1 d%h a9", i, en, d, a, exp_d[i]);
      end
    end
    next_entry(1, en, d, a);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL once_end_en got=%b want=0", en); end
    total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL once_idle got=%b want=0", busy[1]); end
  endtask

  task automatic test_loop_stop();
    logic       en;
    logic [3:0] d, a;
    logic [3:0] exp_d [6];
    exp_d = '{4'h5, 4'hB, 4'h5, 4'hA, 4'h5, 4'hB};
    start_addr = 18'h00100; stop_addr = 18'h00101; att = 4'h3; loop = 1'b1;
    start = 4'b0010;
    wait_ack(1);
    start = '0;
    loop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      next_entry(1, en, d, a);
      total++;
      if (en !== 1'b1 || d !== exp_d[i] || a !== 4'h3) begin
        bad++; $display("FAIL loop_nib%0d got=en%b d%h a%h want=en1 d%h a3", i, en, d, a, exp_d[i]);
      end
    end
    total++; if (busy[1] !== 1'b1) begin bad++; $display("FAIL loop_busy got=%b want=1", busy[1]); end
    stop = 4'b0010;
    wait_ack(1);
    total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL stop_busy got=%b want=0", busy[1]); end
    total++; if (pipe_ch !== 2'd1 || pipe_en !== 1'b1) begin
      bad++; $display("FAIL stop_slot_entry got=ch%0d en%b want=ch1 en1", pipe_ch, pipe_en);
    end
    stop = '0;
    next_entry(1, en, d, a);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL stop_next_en got=%b want=0", en); end
  endtask

  // Voice 2 at 0x200 (0x58) .. 0x203; 0x201 is 0x59
  task automatic test_stall();
    logic       en;
    logic [3:0] d, a;
    int         n;
    start_addr = 18'h00200; stop_addr = 18'h00203; att = 4'h5; loop = 1'b0;
    start = 4'b0100;
    wait_ack(2);
    start = '0;
    n = 0;
    while (rom_cs !== 1'b1 && n < 16) begin tick(); n++; end
    total++; if (rom_addr !== 18'h00200 || rom_cs !== 1'b1) begin
      bad++; $display("FAIL stall_pre got=cs%b addr%h want=cs1 addr00200", rom_cs, rom_addr);
    end
    rom_ok = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (pipe_stb !== 1'b0 || rom_addr !== 18'h00200 || rom_cs !== 1'b1) begin
        bad++; $display("FAIL stall_clk%0d got=stb%b addr%h want=stb0 addr00200", i, pipe_stb, rom_addr);
      end
    end
    rom_ok = 1'b1;
    tick();
    total++;
    if (pipe_stb !== 1'b1 || pipe_ch !== 2'd2 || pipe_en !== 1'b1 || pipe_data !== 4'h5) begin
      bad++; $display("FAIL stall_resume got=stb%b ch%0d en%b d%h want=stb1 ch2 en1 d5",
                      pipe_stb, pipe_ch, pipe_en, pipe_data);
    end
    next_entry(2, en, d, a);
    total++; if (en !== 1'b1 || d !== 4'h8) begin bad++; $display("FAIL stall_nib1 got=en%b d%h want=en1 d8", en, d); end
    next_entry(2, en, d, a);
    total++; if (en !== 1'b1 || d !== 4'h5) begin bad++; $display("FAIL stall_nib2 got=en%b d%h want=en1 d5", en, d); end
    next_entry(2, en, d, a);
    total++; if (en !== 1'b1 || d !== 4'h9) begin bad++; $display("FAIL stall_nib3 got=en%b d%h want=en1 d9", en, d); end
    n = 0;
    while (busy[2] !== 1'b0 && n < 64) begin tick(); n++; end
    total++; if (busy[2] !== 1'b0) begin bad++; $display("FAIL stall_finish got=%b want=0", busy[2]); end
  endtask

  task automatic test_start_stop_same();
    logic       en;
    logic [3:0] d, a;
    int         acks, busys;
    start_addr = 18'h00300; stop_addr = 18'h00310; att = 4'h2; loop = 1'b0;
    start = 4'b0001;
    stop  = 4'b0001;
    wait_ack(0);
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL ss_busy got=%b want=0", busy[0]); end
    start = '0;
    stop  = '0;
    acks = 0;
    busys = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (ack[0] === 1'b1) acks++;
      if (busy[0] !== 1'b0) busys++;
    end
    total++; if (acks != 0)  begin bad++; $display("FAIL ss_extra_ack got=%0d want=0", acks); end
    total++; if (busys != 0) begin bad++; $display("FAIL ss_busy_cycles got=%0d want=0", busys); end
    next_entry(0, en, d, a);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL ss_entry_en got=%b want=0", en); end
  endtask

  // 0x3FFFF=0xA6, 0x3FFFE=0xA7, 0x00000=0x5A, 0x00001=0x5B
  task automatic test_wrap();
    logic       en;
    logic [3:0] d, a;
    logic [3:0] exp0 [4];
    logic [3:0] exp3 [8];
    exp0 = '{4'hA, 4'h6, 4'h5, 4'hA};
    exp3 = '{4'hA, 4'h7, 4'hA, 4'h6, 4'h5, 4'hA, 4'h5, 4'hB};
    start_addr = 18'h3FFFF; stop_addr = 18'h00000; att = 4'h1; loop = 1'b0;
    start = 4'b0001;
    wait_ack(0);
    start = '0;
    for (int i = 0; i < 4; i++) begin
      next_entry(0, en, d, a);
      total++;
      if (en !== 1'b1 || d !== exp0[i]) begin
        bad++; $display("FAIL wrap0_nib%0d got=en%b d%h want=en1 d%h", i, en, d, exp0[i]);
      end
    end
    next_entry(0, en, d, a);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL wrap0_end got=%b want=0", en); end
    start_addr = 18'h3FFFE; stop_addr = 18'h00001; att = 4'hC;
    start = 4'b1000;
    wait_ack(3);
    start = '0;
    for (int i = 0; i < 8; i++) begin
      next_entry(3, en, d, a);
      total++;
      if (en !== 1'b1 || d !== exp3[i] || a !== 4'hC) begin
        bad++; $display("FAIL wrap3_nib%0d got=en%b d%h a%h want=en1 d%h aC", i, en, d, a, exp3[i]);
      end
    end
    next_entry(3, en, d, a);
    total++; if (en !== 1'b0) begin bad++; $display("FAIL wrap3_end got=%b want=0", en); end
    total++; if (busy !== 4'h0) begin bad++; $display("FAIL wrap_idle got=%h want=0", busy); end
  endtask

  // 8-voice instance, voice 5 at 0x040 (0x9A)
  task automatic test_async_reset8();
    int n;
    bit got;
    start_addr = 18'h00040; stop_addr = 18'h00050; att = 4'h7; loop = 1'b0;
    rst8_n = 1'b1;
    start8 = 8'h20;
    n = 0;
    while (ack8[5] !== 1'b1 && n < 64) begin tick(); n++; end
    total++; if (ack8[5] !== 1'b1) begin bad++; $display("FAIL r8_ack got=0 want=1"); end
    start8 = '0;
    for (int i = 0; i < 10; i++) tick();
    total++; if (busy8[5] !== 1'b1) begin bad++; $display("FAIL r8_busy got=%b want=1", busy8[5]); end
    rst8_n = 1'b0;
    #2;
    total++; if (busy8 !== 8'h00 || ack8 !== 8'h00) begin
      bad++; $display("FAIL r8_regs got=busy%h ack%h want=0", busy8, ack8);
    end
    total++; if ({pipe_stb8, pipe_en8, pipe_ch8, pipe_att8, pipe_data8} !== 13'h0) begin
      bad++; $display("FAIL r8_pipe got=%h want=0", {pipe_stb8, pipe_en8, pipe_ch8, pipe_att8, pipe_data8});
    end
    total++; if (zero8 !== 1'b1 || rom_cs8 !== 1'b0 || rom_addr8 !== 18'h0) begin
      bad++; $display("FAIL r8_rom got=zero%b cs%b addr%h want=zero1 cs0 addr0", zero8, rom_cs8, rom_addr8);
    end
    tick();
    rst8_n = 1'b1;
    start8 = 8'h20;
    n = 0;
    while (ack8[5] !== 1'b1 && n < 64) begin tick(); n++; end
    total++; if (ack8[5] !== 1'b1) begin bad++; $display("FAIL r8_reack got=0 want=1"); end
    start8 = '0;
    n = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      tick();
      n++;
      if (pipe_stb8 === 1'b1 && pipe_ch8 === 3'd5) got = 1'b1;
    end
    $display("entry8 ch=5 en=%0b data=%h", pipe_en8, pipe_data8);
    total++; if (!got || pipe_en8 !== 1'b1 || pipe_data8 !== 4'h9) begin
      bad++; $display("FAIL r8_replay got=en%b d%h want=en1 d9", pipe_en8, pipe_data8);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    test_reset();
    test_play_once();
    test_loop_stop();
    test_stall();
    test_start_stop_same();
    test_wrap();
    test_async_reset8();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
